// File: rtl/loop_controller.sv
// Loop controller for a '['/']' instruction set: return-address stack, forward
// skip of zero-entry loops with nesting count, and a sticky fault state.
module loop_controller #(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 16,
  parameter int NEST_WIDTH  = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PC_WIDTH-1:0]                pc,
  input  logic                               is_open,
  input  logic                               is_close,
  input  logic                               data_zero,
  input  logic                               stall,
  output logic                               pc_write,
  output logic                               pc_src,
  output logic [PC_WIDTH-1:0]                pc_loaded,
  output logic                               exec_suppress,
  output logic                               error,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_SKIP,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_depth;
  logic [DW-1:0]         w_depth_nxt;
  logic [NEST_WIDTH-1:0] r_nest;
  logic [NEST_WIDTH-1:0] w_nest_nxt;
  logic                  w_push;
  logic                  w_fault;
  logic                  w_empty;
  logic                  w_full;
  logic [DW-1:0]         w_depth_m1;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_top_idx;
  logic [PC_WIDTH-1:0]   r_stack [2**AW];

  assign w_fault    = is_open & is_close;
  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == DW'(STACK_DEPTH));
  assign w_depth_m1 = r_depth - DW'(1);
  assign w_wr_idx   = r_depth[AW-1:0];
  assign w_top_idx  = w_depth_m1[AW-1:0];

  assign pc_loaded  = w_empty ? '0 : r_stack[w_top_idx] + PC_WIDTH'(1);
  assign error      = (r_state == S_ERROR);
  assign depth      = r_depth;

  always_comb begin
    w_state_nxt   = r_state;
    w_depth_nxt   = r_depth;
    w_nest_nxt    = r_nest;
    w_push        = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    exec_suppress = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_fault) begin
          w_state_nxt   = S_ERROR;
          exec_suppress = 1'b1;
        end else if (!stall) begin
          if (is_open) begin
            if (data_zero) begin
              w_state_nxt   = S_SKIP;
              w_nest_nxt    = NEST_WIDTH'(1);
              pc_write      = 1'b1;
              exec_suppress = 1'b1;
            end else if (w_full) begin
              w_state_nxt   = S_ERROR;
              exec_suppress = 1'b1;
            end else begin
              w_push      = 1'b1;
              w_depth_nxt = r_depth + DW'(1);
              pc_write    = 1'b1;
            end
          end else if (is_close) begin
            if (w_empty) begin
              w_state_nxt   = S_ERROR;
              exec_suppress = 1'b1;
            end else if (data_zero) begin
              w_depth_nxt = w_depth_m1;
              pc_write    = 1'b1;
            end else begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
          end else begin
            pc_write = 1'b1;
          end
        end
      end
      S_SKIP: begin
        exec_suppress = 1'b1;
        if (w_fault) begin
          w_state_nxt = S_ERROR;
        end else if (is_open) begin
          if (r_nest == '1) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_nest_nxt = r_nest + NEST_WIDTH'(1);
            pc_write   = 1'b1;
          end
        end else if (is_close) begin
          pc_write   = 1'b1;
          w_nest_nxt = r_nest - NEST_WIDTH'(1);
          if (r_nest <= NEST_WIDTH'(1)) begin
            w_nest_nxt  = '0;
            w_state_nxt = S_RUN;
          end
        end else begin
          pc_write = 1'b1;
        end
      end
      default: begin
        exec_suppress = 1'b1;
      end
    endcase
    if (reset) begin
      pc_write = 1'b0;
      pc_src   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_depth <= '0;
      r_nest  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_nest  <= w_nest_nxt;
    end
  end

  // Stack contents are not reset; depth alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_stack[w_wr_idx] <= pc;
    end
  end

endmodule
